// File: rtl/pixel_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_shifter
//  Purpose  : Video serialiser. Captures one video byte per Load strobe,
//             latches the display-mode decode and emits one dot per clock
//             as a foreground flag plus a 3-bit palette index. Supports
//             alphanumeric, semigraphics-4, colour graphics (2 bpp) and
//             resolution graphics (1 bpp), with optional double-width dots.
//  Ports    : Clk, Reset (async, active-high)
//             Load, Data[7:0], RowData[7:0], Row[3:0], Inv, Css, AnG,
//             GM[2:0], Divider, selAlpha, selSemi          -> inputs
//             PixOn, Color[2:0], Active, Overrun, Underrun -> registered outputs
//  Revision : 1.0  initial release
// ============================================================================
module pixel_shifter (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Load,
    input  logic [7:0] Data,
    input  logic [7:0] RowData,
    input  logic [3:0] Row,
    input  logic       Inv,
    input  logic       Css,
    input  logic       AnG,
    input  logic [2:0] GM,
    input  logic       Divider,
    input  logic       selAlpha,
    input  logic       selSemi,
    output logic       PixOn,
    output logic [2:0] Color,
    output logic       Active,
    output logic       Overrun,
    output logic       Underrun
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
    typedef enum logic [1:0] {M_ALPHA = 2'd0, M_SEMI = 2'd1, M_CG = 2'd2, M_RG = 2'd3} mode_t;

    state_t      state_q, state_d;
    mode_t       mode_q, mode_d;
    logic [3:0]  cnt_q, cnt_d;          // dot currently on the outputs
    logic [7:0]  data_q, data_d;
    logic [7:0]  rowdata_q, rowdata_d;
    logic [3:0]  row_q, row_d;
    logic        inv_q, inv_d;
    logic        css_q, css_d;
    logic        div_q, div_d;
    logic        pix_on_q, pix_on_d;
    logic [2:0]  color_q, color_d;
    logic        active_q, active_d;
    logic        overrun_q, overrun_d;
    logic        underrun_q, underrun_d;

    logic [3:0]  last_cnt;
    logic [2:0]  dot_idx;
    logic        unused_gm;

    // Only GM[0] distinguishes colour from resolution graphics.
    assign unused_gm = ^GM[2:1];

    assign last_cnt = div_q ? 4'd15 : 4'd7;

    // ------------------------------------------------------------------
    // Sequencing: capture on Load, otherwise advance through the byte.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        rowdata_d  = rowdata_q;
        row_d      = row_q;
        inv_d      = inv_q;
        css_d      = css_q;
        div_d      = div_q;
        overrun_d  = 1'b0;
        underrun_d = 1'b0;

        if (Load) begin
            state_d   = ST_SHIFT;
            cnt_d     = 4'd0;
            data_d    = Data;
            rowdata_d = RowData;
            row_d     = Row;
            inv_d     = Inv;
            css_d     = Css;
            div_d     = Divider;
            if (selAlpha)             mode_d = M_ALPHA;
            else if (selSemi)         mode_d = M_SEMI;
            else if (AnG && !GM[0])   mode_d = M_CG;
            else if (AnG)             mode_d = M_RG;
            else                      mode_d = M_ALPHA;
            // Arriving during the last dot is the seamless cadence, not an overrun.
            overrun_d = (state_q == ST_SHIFT) && (cnt_q != last_cnt);
        end else if (state_q == ST_SHIFT) begin
            if (cnt_q == last_cnt) begin
                state_d    = ST_IDLE;
                cnt_d      = 4'd0;
                underrun_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Dot decode from the values that will be live after this edge, so
    // the registered outputs show dot 0 in the cycle right after Load.
    // ------------------------------------------------------------------
    always_comb begin
        pix_on_d = 1'b0;
        color_d  = 3'd0;
        active_d = (state_d == ST_SHIFT);
        dot_idx  = div_d ? cnt_d[3:1] : cnt_d[2:0];

        if (state_d == ST_SHIFT) begin
            case (mode_d)
                M_ALPHA: begin
                    pix_on_d = rowdata_d[3'd7 - dot_idx] ^ inv_d;
                    color_d  = css_d ? 3'd7 : 3'd0;
                end
                M_SEMI: begin
                    // Upper half of the cell (rows 0-5) uses bits 3/2, lower uses 1/0.
                    if (row_d < 4'd6) pix_on_d = dot_idx[2] ? data_d[2] : data_d[3];
                    else              pix_on_d = dot_idx[2] ? data_d[0] : data_d[1];
                    color_d = data_d[6:4];
                end
                M_CG: begin
                    pix_on_d = 1'b1;
                    case (dot_idx[2:1])
                        2'd0:    color_d = {css_d, data_d[7:6]};
                        2'd1:    color_d = {css_d, data_d[5:4]};
                        2'd2:    color_d = {css_d, data_d[3:2]};
                        default: color_d = {css_d, data_d[1:0]};
                    endcase
                end
                default: begin
                    pix_on_d = data_d[3'd7 - dot_idx];
                    color_d  = css_d ? 3'd4 : 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= M_ALPHA;
            cnt_q      <= 4'd0;
            data_q     <= 8'd0;
            rowdata_q  <= 8'd0;
            row_q      <= 4'd0;
            inv_q      <= 1'b0;
            css_q      <= 1'b0;
            div_q      <= 1'b0;
            pix_on_q   <= 1'b0;
            color_q    <= 3'd0;
            active_q   <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            rowdata_q  <= rowdata_d;
            row_q      <= row_d;
            inv_q      <= inv_d;
            css_q      <= css_d;
            div_q      <= div_d;
            pix_on_q   <= pix_on_d;
            color_q    <= color_d;
            active_q   <= active_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    assign PixOn    = pix_on_q;
    assign Color    = color_q;
    assign Active   = active_q;
    assign Overrun  = overrun_q;
    assign Underrun = underrun_q;

endmodule
`default_nettype wire
